pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard, stall and flush sequencer for the 4-deep integer pipeline: IF, ID, EX, and MEM with write-back in MEM.
- Watches ID source registers, the EX/MEM destinations and the EX-resolved branch.
- Drives PC/IF-ID hold, ID/EX bubble insertion, IF/ID kill and ALU operand forwarding selects.
- Keeps per-stage valid bits so squashed slots never write the register file or memory. Register file is write-before-read, so MEM-stage writes are visible in ID the same cycle.

Parameters:
- FILL_CYCLES, 3, cycles after reset during which all stage valids are forced 0 (pipeline fill).
- BR_KILL, 2, number of younger slots (IF, ID) killed on a taken branch.
- CNT_W, 16, width of the saturating stall/flush performance counters.

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_regwrite  in  1  EX instruction writes a register
- ex_memtoreg  in  1  EX instruction is a load
- ex_towrite  in  5  EX destination register
- mem_regwrite  in  1  MEM instruction writes a register
- mem_towrite  in  5  MEM destination register
- branch_taken  in  1  EX branch resolved taken this cycle
- pc_hold  out  1  freeze PC and IF/ID register
- idex_bubble  out  1  load a NOP into ID/EX
- kill_if  out  1  squash IF slot
- kill_id  out  1  squash ID slot
- ex_valid  out  1  EX slot may commit
- mem_valid  out  1  MEM slot may write regfile/memory
- fwd_a  out  2  ALU A select: 0 regfile, 1 EX result, 2 MEM write data
- fwd_b  out  2  ALU B select, same encoding
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- States: FILL, RUN, STALL, FLUSH.
  - Reset enters FILL with fill counter = FILL_CYCLES-1. All valid bits, counters and outputs are 0, except kill_if and kill_id, which are 1.
- FILL:
  - kill_if = kill_id = 1.
  - Counter decrements each cycle; at 0, go to RUN.
  - branch_taken is ignored.
- Dependency match:
  - Register 0 never matches.
  - Match requires the source's use bit and the producer's regwrite and valid bit.
- Load-use hazard: ex_memtoreg & ex_regwrite & ex_valid, and ex_towrite equals a used ID source.
  - Same-cycle response: pc_hold = 1, idex_bubble = 1; next EX valid = 0.
  - RUN -> STALL for exactly 1 cycle, then STALL -> RUN.
  - In STALL the load is in MEM, so forwarding resolves the dependency.
- Taken branch (RUN or STALL) has priority over a load-use stall.
  - Same cycle: kill_if = kill_id = 1, pc_hold = 0, idex_bubble = 1.
  - flush_cnt increments; next state is FLUSH.
  - FLUSH lasts BR_KILL-1 further cycles with kill_if = 1, then goes to RUN.
  - A branch_taken arriving during FLUSH is ignored, since its slot is already invalid.
- Valid pipeline:
  - Next ex_valid = ID valid & ~idex_bubble & ~kill_id.
  - Next mem_valid = ex_valid.
  - ID valid is a registered copy of IF valid (~kill_if & ~pc_hold retains its value).
- Forwarding, combinational:
  - EX match has priority over MEM match when both name the same register.
  - A load in EX is never selected, because that case stalls.
- stall_cnt increments on each cycle with pc_hold = 1 and saturates at all-ones. flush_cnt saturates the same way.
- Reset asserted mid-stall or mid-flush returns the block to FILL next cycle regardless of inputs.

Optional Feature:
- PIPE_HAZARD_FWD_EN defined:
  - Forwarding as above.
  - Only load-use stalls.
- PIPE_HAZARD_FWD_EN undefined:
  - fwd_a = fwd_b = 0 constantly.
  - Any match against EX or MEM holds (pc_hold = 1, idex_bubble = 1) until no match remains: 1 or 2 cycles, staying in STALL.
  - Branch priority is unchanged.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - State enum (FILL, RUN, STALL, FLUSH).
  - Forwarding encodings FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2.
  - Register-index width 5.
- One sub-module, hazard_match: a combinational comparator giving per-source EX/MEM match bits, instantiated for rs and rt.

Test Plan:
- Reset, then 3 cycles -> kill_if = kill_id = 1 for 3 cycles, ex_valid and mem_valid 0 through fill, RUN on cycle 4, counters 0.
- lw $8 in EX, ID add uses rs = 8 -> same cycle pc_hold = 1, idex_bubble = 1; next cycle fwd_a = 2, stall_cnt = 1.
- add $5 in EX, sub $6 in MEM, ID uses rs = 5 and rt = 6 -> fwd_a = 1, fwd_b = 2, no stall. Both producers write $5 -> fwd_a = 1.
- Load-use on $8 and branch_taken in the same cycle -> kill_if = kill_id = 1, pc_hold = 0, flush_cnt = 1; the stall does not occur and mem_valid is 0 two cycles later.
- EX destination $0 with regwrite -> no stall, fwd 0. stall_cnt preloaded to 0xFFFF plus a stall -> stays 0xFFFF.
- Without PIPE_HAZARD_FWD_EN: add $5 in EX, ID uses $5 -> pc_hold for 2 cycles, fwd_a = 0 throughout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, forwarding selects and register-index width for the
// pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Younger producer (EX) wins when both stages write the same register.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source dependency comparator: flags a live producer in EX and/or MEM
// whose destination equals this ID source register.
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  logic             i_ex_wr,
  input  logic [REG_W-1:0] i_ex_dst,
  input  logic             i_mem_wr,
  input  logic [REG_W-1:0] i_mem_dst,
  output logic             o_ex_match,
  output logic             o_mem_match
);

  logic w_live;

  always_comb begin
    w_live      = i_use && (i_src != '0);
    o_ex_match  = w_live && i_ex_wr && (i_src == i_ex_dst);
    o_mem_match = w_live && i_mem_wr && (i_src == i_mem_dst);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush sequencer for the IF/ID/EX/MEM pipeline.
// PIPE_HAZARD_FWD_EN enables operand forwarding (only load-use stalls).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FILL_CYCLES = 3,
  parameter int unsigned BR_KILL     = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] ex_towrite,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_towrite,
  input  logic             branch_taken,
  output logic             pc_hold,
  output logic             idex_bubble,
  output logic             kill_if,
  output logic             kill_id,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned FILL_W    = (FILL_CYCLES > 2) ? $clog2(FILL_CYCLES) : 1;
  localparam int unsigned KILL_W    = (BR_KILL > 2) ? $clog2(BR_KILL - 1) : 1;
  localparam logic [FILL_W-1:0] FILL_INIT = FILL_W'(FILL_CYCLES - 1);
  localparam logic [KILL_W-1:0] KILL_INIT = KILL_W'((BR_KILL > 1) ? BR_KILL - 2 : 0);

  state_t            r_state;
  state_t            w_next_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [KILL_W-1:0] r_kill_cnt;
  logic              r_id_valid;
  logic              r_ex_valid;
  logic              r_mem_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_flush_evt;
  logic              w_hazard;
  logic              w_rs_ex;
  logic              w_rs_mem;
  logic              w_rt_ex;
  logic              w_rt_mem;

  hazard_match u_match_rs (
    .i_src      (id_rs),
    .i_use      (id_use_rs),
    .i_ex_wr    (ex_regwrite & r_ex_valid),
    .i_ex_dst   (ex_towrite),
    .i_mem_wr   (mem_regwrite & r_mem_valid),
    .i_mem_dst  (mem_towrite),
    .o_ex_match (w_rs_ex),
    .o_mem_match(w_rs_mem)
  );

  hazard_match u_match_rt (
    .i_src      (id_rt),
    .i_use      (id_use_rt),
    .i_ex_wr    (ex_regwrite & r_ex_valid),
    .i_ex_dst   (ex_towrite),
    .i_mem_wr   (mem_regwrite & r_mem_valid),
    .i_mem_dst  (mem_towrite),
    .o_ex_match (w_rt_ex),
    .o_mem_match(w_rt_mem)
  );

`ifdef PIPE_HAZARD_FWD_EN
  // A load in EX has no result yet: it stalls instead of being forwarded.
  always_comb begin
    w_hazard = ex_memtoreg && (w_rs_ex || w_rt_ex);
    fwd_a    = fwd_sel(w_rs_ex && !ex_memtoreg, w_rs_mem);
    fwd_b    = fwd_sel(w_rt_ex && !ex_memtoreg, w_rt_mem);
  end
`else
  logic w_unused_memtoreg;
  always_comb begin
    w_unused_memtoreg = ex_memtoreg;
    w_hazard = w_rs_ex || w_rs_mem || w_rt_ex || w_rt_mem;
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
  end
`endif

  always_comb begin
    w_next_state = r_state;
    pc_hold      = 1'b0;
    idex_bubble  = 1'b0;
    kill_if      = 1'b0;
    kill_id      = 1'b0;
    w_flush_evt  = 1'b0;
    case (r_state)
      S_FILL: begin
        kill_if = 1'b1;
        kill_id = 1'b1;
        if (r_fill_cnt == '0) w_next_state = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (branch_taken) begin
          kill_if      = 1'b1;
          kill_id      = 1'b1;
          idex_bubble  = 1'b1;
          w_flush_evt  = 1'b1;
          w_next_state = (BR_KILL > 1) ? S_FLUSH : S_RUN;
        end else if (w_hazard) begin
          pc_hold      = 1'b1;
          idex_bubble  = 1'b1;
          w_next_state = S_STALL;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FLUSH: begin
        kill_if = 1'b1;
        if (r_kill_cnt == '0) w_next_state = S_RUN;
      end
      default: w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_fill_cnt  <= FILL_INIT;
      r_kill_cnt  <= '0;
      r_id_valid  <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FILL && r_fill_cnt != '0) r_fill_cnt <= r_fill_cnt - 1'b1;
      if (w_flush_evt) r_kill_cnt <= KILL_INIT;
      else if (r_state == S_FLUSH && r_kill_cnt != '0) r_kill_cnt <= r_kill_cnt - 1'b1;
      if (!pc_hold) r_id_valid <= ~kill_if;
      r_ex_valid  <= r_id_valid & ~idex_bubble & ~kill_id;
      r_mem_valid <= r_ex_valid;
      if (pc_hold && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign mem_valid = r_mem_valid;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push the
// expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned TB_CNT_W = 3;
  localparam int          SAT      = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [REG_W-1:0]    id_rs, id_rt, ex_towrite, mem_towrite;
  logic                id_use_rs, id_use_rt, ex_regwrite, ex_memtoreg;
  logic                mem_regwrite, branch_taken;
  logic                pc_hold, idex_bubble, kill_if, kill_id, ex_valid, mem_valid;
  logic [1:0]          fwd_a, fwd_b;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic                hold;
    logic                bub;
    logic                kif;
    logic                kid;
    logic                exv;
    logic                memv;
    logic [1:0]          fa;
    logic [1:0]          fb;
    logic [TB_CNT_W-1:0] sc;
    logic [TB_CNT_W-1:0] fc;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .FILL_CYCLES(3),
    .BR_KILL    (2),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memtoreg (ex_memtoreg),
    .ex_towrite  (ex_towrite),
    .mem_regwrite(mem_regwrite),
    .mem_towrite (mem_towrite),
    .branch_taken(branch_taken),
    .pc_hold     (pc_hold),
    .idex_bubble (idex_bubble),
    .kill_if     (kill_if),
    .kill_id     (kill_id),
    .ex_valid    (ex_valid),
    .mem_valid   (mem_valid),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // One clock of stimulus plus the outputs expected for that cycle.
  task automatic cyc(input string nm,
                     input int rst, rs, urs, rt, urt, exrw, exmtr, exdst, memrw, memdst, br,
                     input int hold, bub, kif, kid, exv, memv, fa, fb, sc, fc);
    out_t e;
    @(posedge clk);
    #1;
    reset        = 1'(rst);
    id_rs        = REG_W'(rs);
    id_use_rs    = 1'(urs);
    id_rt        = REG_W'(rt);
    id_use_rt    = 1'(urt);
    ex_regwrite  = 1'(exrw);
    ex_memtoreg  = 1'(exmtr);
    ex_towrite   = REG_W'(exdst);
    mem_regwrite = 1'(memrw);
    mem_towrite  = REG_W'(memdst);
    branch_taken = 1'(br);
    e.hold = 1'(hold);
    e.bub  = 1'(bub);
    e.kif  = 1'(kif);
    e.kid  = 1'(kid);
    e.exv  = 1'(exv);
    e.memv = 1'(memv);
    e.fa   = 2'(fa);
    e.fb   = 2'(fb);
    e.sc   = TB_CNT_W'(sc);
    e.fc   = TB_CNT_W'(fc);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        out_t  e_v;
        out_t  a_v;
        string n_v;
        e_v = exp_q.pop_front();
        n_v = name_q.pop_front();
        a_v = {pc_hold, idex_bubble, kill_if, kill_id, ex_valid, mem_valid,
               fwd_a, fwd_b, stall_cnt, flush_cnt};
        checks++;
        if (a_v !== e_v) begin
          errors++;
          $display("FAIL %s: got hold=%b bub=%b kif=%b kid=%b exv=%b memv=%b fa=%0d fb=%0d sc=%0d fc=%0d, want hold=%b bub=%b kif=%b kid=%b exv=%b memv=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                   n_v, a_v.hold, a_v.bub, a_v.kif, a_v.kid, a_v.exv, a_v.memv, a_v.fa, a_v.fb, a_v.sc, a_v.fc,
                   e_v.hold, e_v.bub, e_v.kif, e_v.kid, e_v.exv, e_v.memv, e_v.fa, e_v.fb, e_v.sc, e_v.fc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset = 1'b1;
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_towrite = '0;
    mem_regwrite = 1'b0; mem_towrite = '0; branch_taken = 1'b0;

    //      name          rst rs u rt u exw mtr exd mw md br | hold bub kif kid exv memv fa fb sc fc
    cyc("rst_a",          1, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,1,1,0,0,0,0,0,0);
    cyc("rst_b",          1, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,1,1,0,0,0,0,0,0);
    cyc("fill1_br_ign",   0, 0,0, 0,0, 0,0,0, 0,0, 1,   0,0,1,1,0,0,0,0,0,0);
    cyc("fill2",          0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,1,1,0,0,0,0,0,0);
    cyc("fill3",          0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,1,1,0,0,0,0,0,0);
    cyc("run1",           0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,0,0);
    cyc("run2",           0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,0,0);
    cyc("run3_exv",       0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,0,0,0,0,0);
    cyc("zero_reg",       0, 0,1, 0,1, 1,0,0, 1,0, 0,   0,0,0,0,1,1,0,0,0,0);

`ifdef PIPE_HAZARD_FWD_EN
    cyc("fwd_ex_mem",     0, 5,1, 6,1, 1,0,5, 1,6, 0,   0,0,0,0,1,1,1,2,0,0);
    cyc("fwd_ex_prio",    0, 5,1, 0,0, 1,0,5, 1,5, 0,   0,0,0,0,1,1,1,0,0,0);
    cyc("lu_detect",      0, 8,1, 0,0, 1,1,8, 0,0, 0,   1,1,0,0,1,1,0,0,0,0);
    cyc("lu_fwd_mem",     0, 8,1, 0,0, 0,0,0, 1,8, 0,   0,0,0,0,0,1,2,0,1,0);
    cyc("lu_resume",      0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,0,0,0,1,0);
    cyc("pre_branch",     0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,1,0,0,1,0);
    cyc("br_over_lu",     0, 8,1, 0,0, 1,1,8, 0,0, 1,   0,1,1,1,1,1,0,0,1,0);
    cyc("flush_br_ign",   0, 0,0, 0,0, 0,0,0, 0,0, 1,   0,0,1,0,0,1,0,0,1,1);
    cyc("post_flush",     0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,1,1);
    cyc("refill1",        0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,1,1);
    cyc("refill2",        0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,0,0,0,1,1);
    for (int i = 0; i < 7; i++) begin
      r = i + 1;
      cyc($sformatf("lu_rt_%0d", i),  0, 0,0, r,1, 1,1,r, 0,0, 0,
          1,1,0,0,1,(i == 0) ? 1 : 0,0,0,sat(1 + i),1);
      cyc($sformatf("lu_fwdb_%0d", i), 0, 0,0, r,1, 0,0,0, 1,r, 0,
          0,0,0,0,0,1,0,2,sat(2 + i),1);
    end
    cyc("rstmid_lu",      0, 0,0,20,1, 1,1,20,0,0, 0,   1,1,0,0,1,0,0,0,SAT,1);
    cyc("rstmid_stall",   1, 0,0,20,1, 0,0,0, 1,20,0,   0,0,0,0,0,1,0,2,SAT,1);
`else
    cyc("nf_ex_hold",     0, 5,1, 0,0, 1,0,5, 0,0, 0,   1,1,0,0,1,1,0,0,0,0);
    cyc("nf_mem_hold",    0, 5,1, 0,0, 0,0,0, 1,5, 0,   1,1,0,0,0,1,0,0,1,0);
    cyc("nf_release",     0, 5,1, 0,0, 0,0,0, 1,5, 0,   0,0,0,0,0,0,0,0,2,0);
    cyc("nf_resume",      0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,0,0,0,2,0);
    cyc("nf_pre",         0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,1,0,0,2,0);
    cyc("nf_two_src",     0, 5,1, 6,1, 1,0,5, 1,6, 0,   1,1,0,0,1,1,0,0,2,0);
    cyc("nf_two_mem",     0, 5,1, 6,1, 0,0,0, 1,5, 0,   1,1,0,0,0,1,0,0,3,0);
    cyc("nf_two_rel",     0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,4,0);
    cyc("nf_run1",        0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,0,0,0,4,0);
    cyc("nf_br_over",     0, 5,1, 0,0, 1,0,5, 0,0, 1,   0,1,1,1,1,1,0,0,4,0);
    cyc("nf_flush_ign",   0, 0,0, 0,0, 0,0,0, 0,0, 1,   0,0,1,0,0,1,0,0,4,1);
    cyc("nf_post_flush",  0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,4,1);
    cyc("nf_refill1",     0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,4,1);
    cyc("nf_refill2",     0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,1,0,0,0,4,1);
    for (int i = 0; i < 2; i++) begin
      r = i + 9;
      cyc($sformatf("nf_rt_ex_%0d", i),  0, 0,0, r,1, 1,0,r, 0,0, 0,
          1,1,0,0,1,(i == 0) ? 1 : 0,0,0,4 + 2 * i,1);
      cyc($sformatf("nf_rt_mem_%0d", i), 0, 0,0, r,1, 0,0,0, 1,r, 0,
          1,1,0,0,0,1,0,0,5 + 2 * i,1);
      cyc($sformatf("nf_rt_rel_%0d", i), 0, 0,0, r,1, 0,0,0, 1,r, 0,
          0,0,0,0,0,0,0,0,sat(6 + 2 * i),1);
    end
    cyc("nf_rstmid_ex",   0, 0,0,20,1, 1,0,20,0,0, 0,   1,1,0,0,1,0,0,0,SAT,1);
    cyc("nf_rstmid_stall",1, 0,0,20,1, 0,0,0, 1,20,0,   1,1,0,0,0,1,0,0,SAT,1);
`endif

    cyc("refill_a_ign",   0, 8,1, 8,1, 1,1,8, 1,8, 1,   0,0,1,1,0,0,0,0,0,0);
    cyc("refill_b",       0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,1,1,0,0,0,0,0,0);
    cyc("refill_c",       0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,1,1,0,0,0,0,0,0);
    cyc("rerun",          0, 0,0, 0,0, 0,0,0, 0,0, 0,   0,0,0,0,0,0,0,0,0,0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
